// File: rtl/cmp_config_mc.sv
// Comparator configuration parser: turns the pkt_comm configuration byte stream
// into comparator hash-table rows plus the binary-search start address and step.
module cmp_config_mc #(
    parameter int unsigned SALT_BYTES = 2,
    parameter int unsigned SALT_BITS  = 12,
    parameter int unsigned ITER_EN    = 0,
    parameter int unsigned HASH_BITS  = 35,
    parameter int unsigned ADDR_BITS  = 12,
    parameter logic [7:0]  MAGIC      = 8'hCC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           din,
    input  logic                 wr_en,
    output logic                 full,
    output logic [SALT_BITS-1:0] salt_out,
    output logic [31:0]          iter_out,
    output logic [ADDR_BITS-2:0] read_addr_start,
    output logic [ADDR_BITS-2:0] addr_diff_start,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [HASH_BITS-1:0] hash_out,
    output logic [ADDR_BITS-1:0] hash_addr_out,
    output logic                 hash_valid,
    output logic                 hash_end,
    output logic                 new_cmp_config,
    input  logic                 config_applied,
    output logic                 error
);

    localparam int unsigned HASH_BYTES = (HASH_BITS + 7) / 8;
    localparam int unsigned HASH_W8    = 8 * HASH_BYTES;
    localparam int unsigned SALT_W8    = 8 * SALT_BYTES;
    localparam int unsigned HBUF_W     = HASH_W8 - 8;
    localparam int unsigned SBUF_W     = SALT_W8 - 8;
    localparam int unsigned SA_BITS    = ADDR_BITS - 1;
    localparam int unsigned CNT_W      = ADDR_BITS + 1;
    localparam int unsigned MAX_ROWS   = (1 << ADDR_BITS) - 1;

    typedef enum logic [2:0] {
        S_SALT, S_ITER, S_NUM, S_HASH, S_FILL, S_MAGIC, S_ERROR
    } state_t;

    state_t               state;
    logic [7:0]           byte_idx;
    logic [SBUF_W-1:0]    salt_buf;
    logic [HBUF_W-1:0]    hash_buf;
    logic [7:0]           num_lo;
    logic [ADDR_BITS-1:0] num_rows;
    logic [ADDR_BITS-1:0] prev_rows;
    logic [ADDR_BITS-1:0] count;
    logic [HASH_BITS-1:0] prev_hash;
    logic                 have_prev;
    logic                 configured;
    logic                 applied_q;
    logic                 end_sent;
    logic                 end_done;

    logic                 accept_c;
    logic                 load_ok_c;
    logic                 fill_end_c;
    logic [SALT_W8-1:0]   salt_word_c;
    logic [HASH_W8-1:0]   hash_word_c;
    logic [15:0]          num_c;
    logic [SA_BITS-1:0]   start_c;
    logic [SA_BITS-1:0]   diff_c;
    logic [ADDR_BITS-1:0] fill_limit_c;
    logic [CNT_W-1:0]     count_p1_c;

    // Set every bit below the highest set bit.
    function automatic logic [SA_BITS-1:0] smear(input logic [SA_BITS-1:0] x);
        logic [SA_BITS-1:0] r;
        r = x;
        for (int i = 1; i < int'(SA_BITS); i++) begin
            r = r | (x >> i);
        end
        return r;
    endfunction

    assign full = out_valid || (state == S_FILL) || (state == S_ERROR);

    always_comb begin
        accept_c     = wr_en && !full;
        load_ok_c    = !out_valid || out_ready;
        salt_word_c  = {din, salt_buf};
        hash_word_c  = {din, hash_buf};
        num_c        = {din, num_lo};
        start_c      = smear(num_c[ADDR_BITS-1:1]);
        diff_c       = start_c ^ (start_c >> 1);
        // Unconfigured tables are filled to the last usable row.
        fill_limit_c = configured ? prev_rows : ADDR_BITS'(MAX_ROWS);
        count_p1_c   = {1'b0, count} + CNT_W'(1);
        fill_end_c   = count_p1_c >= {1'b0, fill_limit_c};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_SALT;
            byte_idx        <= '0;
            salt_buf        <= '0;
            hash_buf        <= '0;
            num_lo          <= '0;
            num_rows        <= '0;
            prev_rows       <= '0;
            count           <= '0;
            prev_hash       <= '0;
            have_prev       <= 1'b0;
            configured      <= 1'b0;
            applied_q       <= 1'b0;
            end_sent        <= 1'b0;
            end_done        <= 1'b0;
            salt_out        <= '0;
            iter_out        <= '0;
            read_addr_start <= '1;
            addr_diff_start <= {1'b1, {(SA_BITS-1){1'b0}}};
            out_valid       <= 1'b0;
            hash_out        <= '0;
            hash_addr_out   <= '0;
            hash_valid      <= 1'b0;
            hash_end        <= 1'b0;
            new_cmp_config  <= 1'b0;
            error           <= 1'b0;
        end else begin
            if (config_applied && new_cmp_config) begin
                applied_q      <= 1'b1;
                new_cmp_config <= 1'b0;
            end

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                if (hash_end) begin
                    end_done <= 1'b1;
                end
            end

            case (state)
                S_SALT: if (accept_c) begin
                    if (32'(byte_idx) == SALT_BYTES - 1) begin
                        byte_idx <= '0;
                        if ((salt_word_c >> SALT_BITS) != '0) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else begin
                            salt_out <= salt_word_c[SALT_BITS-1:0];
                            state    <= (ITER_EN != 0) ? S_ITER : S_NUM;
                        end
                    end else begin
                        salt_buf <= (salt_buf >> 8) | (SBUF_W'(din) << (SBUF_W - 8));
                        byte_idx <= byte_idx + 8'd1;
                    end
                end

                S_ITER: if (accept_c) begin
                    iter_out <= {din, iter_out[31:8]};
                    if (byte_idx == 8'd3) begin
                        byte_idx <= '0;
                        state    <= S_NUM;
                    end else begin
                        byte_idx <= byte_idx + 8'd1;
                    end
                end

                S_NUM: if (accept_c) begin
                    if (byte_idx == 8'd0) begin
                        num_lo   <= din;
                        byte_idx <= 8'd1;
                    end else begin
                        byte_idx <= '0;
                        if (num_c == 16'd0 || 32'(num_c) > MAX_ROWS) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else begin
                            num_rows        <= ADDR_BITS'(num_c);
                            new_cmp_config  <= 1'b1;
                            read_addr_start <= start_c;
                            addr_diff_start <= diff_c;
                            count           <= '0;
                            have_prev       <= 1'b0;
                            state           <= S_HASH;
                        end
                    end
                end

                S_HASH: if (accept_c) begin
                    if (32'(byte_idx) == HASH_BYTES - 1) begin
                        byte_idx <= '0;
                        if ((hash_word_c >> HASH_BITS) != '0) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else if (have_prev && hash_word_c[HASH_BITS-1:0] <= prev_hash) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else begin
                            prev_hash     <= hash_word_c[HASH_BITS-1:0];
                            have_prev     <= 1'b1;
                            out_valid     <= 1'b1;
                            hash_out      <= hash_word_c[HASH_BITS-1:0];
                            hash_addr_out <= count;
                            hash_valid    <= 1'b1;
                            hash_end      <= 1'b0;
                            count         <= count + 1'b1;
                            if (count + 1'b1 == num_rows) begin
                                end_sent <= 1'b0;
                                end_done <= 1'b0;
                                state    <= S_FILL;
                            end
                        end
                    end else begin
                        hash_buf <= (hash_buf >> 8) | (HBUF_W'(din) << (HBUF_W - 8));
                        byte_idx <= byte_idx + 8'd1;
                    end
                end

                S_FILL: begin
                    // The end row never advances the counter past the last row.
                    if (!end_sent && load_ok_c) begin
                        out_valid     <= 1'b1;
                        hash_out      <= '0;
                        hash_addr_out <= count;
                        hash_valid    <= 1'b0;
                        hash_end      <= fill_end_c;
                        if (fill_end_c) begin
                            end_sent <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    if (end_done && applied_q) begin
                        applied_q <= 1'b0;
                        state     <= S_MAGIC;
                    end
                end

                S_MAGIC: if (accept_c) begin
                    if (din == MAGIC) begin
                        prev_rows  <= num_rows;
                        configured <= 1'b1;
                        state      <= S_SALT;
                    end else begin
                        state <= S_ERROR;
                        error <= 1'b1;
                    end
                end

                S_ERROR: state <= S_ERROR;

                default: begin
                    state <= S_ERROR;
                    error <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_config_mc.sv
// Scoreboard bench for cmp_config_mc: directed configuration streams, rows checked
// by an independent monitor against expected rows queued by the stimulus.
module tb_cmp_config_mc;

    localparam int unsigned ADDR_BITS = 4;
    localparam int unsigned HASH_BITS = 35;
    localparam int unsigned SALT_BITS = 12;
    localparam logic [7:0]  MAGIC     = 8'hCC;

    typedef struct packed {
        logic [HASH_BITS-1:0] hash;
        logic [ADDR_BITS-1:0] addr;
        logic                 v;
        logic                 e;
    } row_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [7:0]           din;
    logic                 wr_en;
    logic                 full;
    logic [SALT_BITS-1:0] salt_out;
    logic [31:0]          iter_out;
    logic [ADDR_BITS-2:0] read_addr_start;
    logic [ADDR_BITS-2:0] addr_diff_start;
    logic                 out_valid;
    logic                 out_ready;
    logic [HASH_BITS-1:0] hash_out;
    logic [ADDR_BITS-1:0] hash_addr_out;
    logic                 hash_valid;
    logic                 hash_end;
    logic                 new_cmp_config;
    logic                 config_applied;
    logic                 error;

    row_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   m_configured = 1'b0;
    int   m_prev = 0;

    always #5 clk = ~clk;

    cmp_config_mc #(
        .SALT_BYTES(2), .SALT_BITS(SALT_BITS), .ITER_EN(0),
        .HASH_BITS(HASH_BITS), .ADDR_BITS(ADDR_BITS), .MAGIC(MAGIC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .full(full),
        .salt_out(salt_out), .iter_out(iter_out),
        .read_addr_start(read_addr_start), .addr_diff_start(addr_diff_start),
        .out_valid(out_valid), .out_ready(out_ready), .hash_out(hash_out),
        .hash_addr_out(hash_addr_out), .hash_valid(hash_valid), .hash_end(hash_end),
        .new_cmp_config(new_cmp_config), .config_applied(config_applied), .error(error)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Row monitor: pops one expected row per handshake.
    initial begin
        row_t r;
        row_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                r = '{hash: hash_out, addr: hash_addr_out, v: hash_valid, e: hash_end};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL row: got unexpected addr=%0d v=%0b e=%0b hash=0x%0h, want no row",
                             r.addr, r.v, r.e, r.hash);
                end else begin
                    e = exp_q.pop_front();
                    if (r !== e) begin
                        n_err++;
                        $display("FAIL row: got addr=%0d v=%0b e=%0b hash=0x%0h, want addr=%0d v=%0b e=%0b hash=0x%0h",
                                 r.addr, r.v, r.e, r.hash, e.addr, e.v, e.e, e.hash);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int exp_start(input int n);
        int s;
        s = n >> 1;
        if (s == 0) return 0;
        return (1 << $clog2(s + 1)) - 1;
    endfunction

    function automatic int exp_diff(input int n);
        return (exp_start(n) + 1) >> 1;
    endfunction

    function automatic logic [HASH_BITS-1:0] hash_of(input int cfg, input int i);
        return HASH_BITS'(64'h1_0000_0000 + 64'(i) * 64'h0101_0101 + 64'(cfg));
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b0;
        din   = b;
        wr_en = 1'b1;
        while (!ok && t < 400) begin
            ok = !full;
            @(negedge clk);
            t++;
        end
        wr_en = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_byte: byte 0x%0h never accepted (full=%0b), want accepted", b, full);
        end
    endtask

    task automatic send_hash(input logic [HASH_BITS-1:0] h);
        logic [39:0] w;
        w = 40'(h);
        for (int k = 0; k < 5; k++) begin
            send_byte(8'(w >> (8 * k)));
        end
    endtask

    task automatic push_row(input logic [HASH_BITS-1:0] h, input int a, input bit v, input bit e);
        row_t r;
        r = '{hash: h, addr: ADDR_BITS'(a), v: v, e: e};
        exp_q.push_back(r);
    endtask

    task automatic push_fillers(input int n);
        int  limit;
        int  c;
        bit  e;
        limit = m_configured ? m_prev : 15;
        c = n;
        do begin
            e = (c + 1 >= limit);
            push_row('0, c, 1'b0, e);
            c++;
        end while (!e);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("rows drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_applied();
        config_applied = 1'b1;
        @(negedge clk);
        config_applied = 1'b0;
        check("new_cmp_config cleared", 64'(new_cmp_config), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        config_applied = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        exp_q.delete();
        m_configured = 1'b0;
        m_prev = 0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_config(input int cfg, input int n, input bit bp, input bit early,
                              input bit top_last, input logic [7:0] mg);
        logic [HASH_BITS-1:0] h;
        send_byte(8'h34);
        send_byte(8'h02);
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        check("new_cmp_config set", 64'(new_cmp_config), 64'd1);
        check("read_addr_start", 64'(read_addr_start), 64'(exp_start(n)));
        check("addr_diff_start", 64'(addr_diff_start), 64'(exp_diff(n)));
        if (early) pulse_applied();
        for (int i = 0; i < n; i++) begin
            h = (top_last && i == n - 1) ? '1 : hash_of(cfg, i);
            push_row(h, i, 1'b1, 1'b0);
            if (i == n - 1) push_fillers(n);
            if (bp && i == 0) out_ready = 1'b0;
            send_hash(h);
            if (bp && i == 0) begin
                repeat (10) begin
                    check("bp out_valid", 64'(out_valid), 64'd1);
                    check("bp full", 64'(full), 64'd1);
                    check("bp hash_out", 64'(hash_out), 64'(h));
                    check("bp hash_addr_out", 64'(hash_addr_out), 64'd0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        end
        wait_drain();
        check("salt_out", 64'(salt_out), 64'h234);
        if (!early) begin
            repeat (3) @(negedge clk);
            check("fill hold full", 64'(full), 64'd1);
            check("fill hold out_valid", 64'(out_valid), 64'd0);
            check("fill hold new_cmp_config", 64'(new_cmp_config), 64'd1);
            pulse_applied();
        end
        send_byte(mg);
        if (mg == MAGIC) begin
            m_prev = n;
            m_configured = 1'b1;
            check("no error after magic", 64'(error), 64'd0);
            check("full after magic", 64'(full), 64'd0);
        end
    endtask

    task automatic expect_err(input string name);
        check({name, " error"}, 64'(error), 64'd1);
        check({name, " full"}, 64'(full), 64'd1);
        repeat (5) @(negedge clk);
        check({name, " error sticky"}, 64'(error), 64'd1);
        check({name, " full sticky"}, 64'(full), 64'd1);
        do_reset();
        check({name, " error after reset"}, 64'(error), 64'd0);
    endtask

    initial begin
        logic [HASH_BITS-1:0] h;
        rst_n = 1'b0;
        din = '0;
        wr_en = 1'b0;
        out_ready = 1'b1;
        config_applied = 1'b0;
        repeat (2) @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset full", 64'(full), 64'd0);
        check("reset error", 64'(error), 64'd0);
        check("reset read_addr_start", 64'(read_addr_start), 64'h7);
        check("reset addr_diff_start", 64'(addr_diff_start), 64'h4);
        check("reset salt_out", 64'(salt_out), 64'd0);
        check("reset iter_out", 64'(iter_out), 64'd0);
        check("reset new_cmp_config", 64'(new_cmp_config), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // First config then a series of resizes, ending with a full table.
        run_config(1, 2, 1'b0, 1'b1, 1'b0, MAGIC);
        run_config(2, 3, 1'b1, 1'b0, 1'b0, MAGIC);
        run_config(3, 1, 1'b0, 1'b1, 1'b0, MAGIC);
        run_config(4, 3, 1'b0, 1'b0, 1'b0, MAGIC);
        run_config(5, 5, 1'b0, 1'b1, 1'b0, MAGIC);
        check("N=5 read_addr_start", 64'(read_addr_start), 64'h3);
        check("N=5 addr_diff_start", 64'(addr_diff_start), 64'h2);
        run_config(6, 15, 1'b0, 1'b1, 1'b1, MAGIC);
        check("N=15 read_addr_start", 64'(read_addr_start), 64'h7);
        check("N=15 addr_diff_start", 64'(addr_diff_start), 64'h4);
        iter_chk: check("iter_out stays 0", 64'(iter_out), 64'd0);

        // Error cases.
        do_reset();
        send_byte(8'h00); send_byte(8'h10);
        expect_err("salt pad");

        send_byte(8'h34); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        expect_err("N=0");

        send_byte(8'h34); send_byte(8'h02); send_byte(8'h10); send_byte(8'h00);
        expect_err("N=16");

        send_byte(8'h34); send_byte(8'h02); send_byte(8'h02); send_byte(8'h00);
        h = hash_of(7, 0);
        push_row(h, 0, 1'b1, 1'b0);
        send_hash(h);
        send_hash(h);
        wait_drain();
        expect_err("equal hash");

        send_byte(8'h34); send_byte(8'h02); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'hF8);
        expect_err("hash pad");

        run_config(8, 1, 1'b0, 1'b1, 1'b0, 8'hCD);
        expect_err("bad magic");

        // Reset while a row is pending in the middle of the hash list.
        send_byte(8'h34); send_byte(8'h02); send_byte(8'h03); send_byte(8'h00);
        out_ready = 1'b0;
        send_hash(hash_of(9, 0));
        check("pending row before reset", 64'(out_valid), 64'd1);
        check("N=3 read_addr_start", 64'(read_addr_start), 64'h1);
        rst_n = 1'b0;
        #1;
        check("reset drops row", 64'(out_valid), 64'd0);
        check("reset read_addr_start mid", 64'(read_addr_start), 64'h7);
        check("reset new_cmp_config mid", 64'(new_cmp_config), 64'd0);
        @(negedge clk);
        exp_q.delete();
        m_configured = 1'b0;
        m_prev = 0;
        out_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        run_config(10, 2, 1'b0, 1'b1, 1'b0, MAGIC);

        repeat (5) @(negedge clk);
        check("no leftover rows", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
